// File: rtl/mdio_defs.sv
// rtl/mdio_defs.sv - shared constants, frame field positions and FSM states for the MDIO master
package mdio_defs;

  // Clause-22 start and opcode values
  localparam logic [1:0] ST_C22 = 2'b01;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_RD  = 2'b10;

  // Transaction word field positions
  localparam int ST_MSB    = 31;
  localparam int ST_LSB    = 30;
  localparam int OP_MSB    = 29;
  localparam int OP_LSB    = 28;
  localparam int PHY_MSB   = 27;
  localparam int PHY_LSB   = 23;
  localparam int REG_MSB   = 22;
  localparam int REG_LSB   = 18;
  localparam int TA_MSB    = 17;
  localparam int TA_LSB    = 16;
  localparam int DATA_MSB  = 15;
  localparam int DATA_LSB  = 0;

  // Frame cell layout
  localparam int FRAME_LEN = 32;
  localparam int FRAME_MSB = 31;
  localparam int TA_CELL   = 14;  // first cell released on a read
  localparam int RD_CELL   = 16;  // first cell carrying PHY read data

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PREAMBLE = 2'd1,
    S_FRAME    = 2'd2,
    S_DONE     = 2'd3
  } state_e;

endpackage

// File: rtl/mdio_clk_gen.sv
// rtl/mdio_clk_gen.sv - MDC divider with rise/fall strobes marking the clk edge where MDC changes
module mdio_clk_gen #(
  parameter int HALF_PERIOD = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic mdc,
  output logic mdc_rise,
  output logic mdc_fall
);

  localparam int CW = $clog2(HALF_PERIOD) + 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          mdc_q, mdc_d;
  logic          last;

  assign last     = (cnt_q == CW'(HALF_PERIOD - 1));
  // Strobes are high in the cycle whose closing edge toggles MDC
  assign mdc_rise = en & last & ~mdc_q;
  assign mdc_fall = en & last &  mdc_q;
  assign mdc      = mdc_q;

  // Count half-periods while enabled; park MDC low and restart the count when disabled
  always_comb begin
    cnt_d = cnt_q;
    mdc_d = mdc_q;
    if (!en) begin
      cnt_d = '0;
      mdc_d = 1'b0;
    end else if (last) begin
      cnt_d = '0;
      mdc_d = ~mdc_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Divider state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      mdc_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      mdc_q <= mdc_d;
    end
  end

endmodule

// File: rtl/mdio_master_ctrl.sv
// rtl/mdio_master_ctrl.sv - Clause-22 MDIO station-management sequencer (preamble, frame, read capture)
module mdio_master_ctrl #(
  parameter int HALF_PERIOD = 2,
  parameter int PRE_LEN     = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        t_valid,
  input  logic [31:0] t_data,
  output logic        t_ready,
  output logic        mdc,
  output logic        mdio_out,
  output logic        mdio_oe,
  input  logic        mdio_in,
  output logic [15:0] rd_data,
  output logic        done,
  output logic        err
);

  import mdio_defs::*;

  state_e      state_q, state_d;
  logic [31:0] word_q, word_d;
  logic        is_read_q, is_read_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] shift_q, shift_d;
  logic        mdio_out_q, mdio_out_d;
  logic        mdio_oe_q, mdio_oe_d;
  logic [15:0] rd_data_q, rd_data_d;
  logic        t_ready_q, t_ready_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        clk_en;
  logic        mdc_rise;
  logic        mdc_fall;
  logic [5:0]  nxt_cnt;
  logic [4:0]  frame_idx;
  logic        released;

  // MDC only runs while a preamble or frame is being shifted out
  assign clk_en = (state_q == S_PREAMBLE) || (state_q == S_FRAME);

  mdio_clk_gen #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_clk_gen (
    .clk      (clk),
    .reset    (reset),
    .en       (clk_en),
    .mdc      (mdc),
    .mdc_rise (mdc_rise),
    .mdc_fall (mdc_fall)
  );

  // Next-state: cells advance on MDC fall, read bits are captured on MDC rise
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    is_read_d  = is_read_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    mdio_out_d = mdio_out_q;
    mdio_oe_d  = mdio_oe_q;
    rd_data_d  = rd_data_q;
    t_ready_d  = t_ready_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    nxt_cnt    = bit_cnt_q + 6'd1;
    frame_idx  = 5'(6'd31 - nxt_cnt);
    released   = is_read_q && (nxt_cnt >= 6'(TA_CELL));

    case (state_q)
      S_IDLE: begin
        if (t_valid && t_ready_q) begin
          if (t_data[ST_MSB:ST_LSB] == ST_C22) begin
            word_d     = t_data;
            is_read_d  = (t_data[OP_MSB:OP_LSB] == OP_RD);
            bit_cnt_d  = 6'd0;
            shift_d    = 16'h0000;
            mdio_out_d = 1'b1;
            mdio_oe_d  = 1'b1;
            t_ready_d  = 1'b0;
            state_d    = S_PREAMBLE;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_PREAMBLE: begin
        if (mdc_fall) begin
          mdio_oe_d = 1'b1;
          if (bit_cnt_q == 6'(PRE_LEN - 1)) begin
            bit_cnt_d  = 6'd0;
            mdio_out_d = word_q[FRAME_MSB];
            state_d    = S_FRAME;
          end else begin
            bit_cnt_d  = nxt_cnt;
            mdio_out_d = 1'b1;
          end
        end
      end

      S_FRAME: begin
        if (mdc_rise && is_read_q && (bit_cnt_q >= 6'(RD_CELL))) begin
          shift_d = {shift_q[14:0], mdio_in};
        end
        if (mdc_fall) begin
          if (bit_cnt_q == 6'(FRAME_LEN - 1)) begin
            bit_cnt_d  = 6'd0;
            mdio_out_d = 1'b1;
            mdio_oe_d  = 1'b0;
            state_d    = S_DONE;
          end else begin
            bit_cnt_d  = nxt_cnt;
            // Released cells still drive a harmless 1 into the (disabled) pad driver
            mdio_out_d = released ? 1'b1 : word_q[frame_idx];
            mdio_oe_d  = ~released;
          end
        end
      end

      S_DONE: begin
        if (is_read_q) begin
          rd_data_d = shift_q;
        end
        done_d    = 1'b1;
        t_ready_d = 1'b1;
        state_d   = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Register FSM state, datapath and all outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      word_q     <= 32'h0000_0000;
      is_read_q  <= 1'b0;
      bit_cnt_q  <= 6'd0;
      shift_q    <= 16'h0000;
      mdio_out_q <= 1'b1;
      mdio_oe_q  <= 1'b0;
      rd_data_q  <= 16'h0000;
      t_ready_q  <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      is_read_q  <= is_read_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      mdio_out_q <= mdio_out_d;
      mdio_oe_q  <= mdio_oe_d;
      rd_data_q  <= rd_data_d;
      t_ready_q  <= t_ready_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign t_ready  = t_ready_q;
  assign mdio_out = mdio_out_q;
  assign mdio_oe  = mdio_oe_q;
  assign rd_data  = rd_data_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule
